// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
//   Raster timing generator and pixel fetcher feeding three TMDS encoders.
//   h/v counters walk sync -> back porch -> active -> front porch. Pixels are
//   requested from an upstream source one cycle ahead of capture. Decoded
//   de/sync and captured pixel data reach the encoder inputs two cycles after
//   the matching request.
// Ports:
//   sys_clk, sys_rst      pixel clock, synchronous active-high reset
//   en                    run request, acted on only at frame boundaries
//   pix_req, pix_sof      pixel request / first-request-of-frame pulse
//   pix_data, pix_valid   source response, sampled the cycle after pix_req
//   enc_r/g/b, enc_de     encoder data and shared data-enable
//   enc_hsync, enc_vsync  sync levels for blue-channel c0/c1
//   underflow             sticky flag, cleared by underflow_clr
//   running               high in RUN or DRAIN
module hdmi_video_timing_ctrl #(
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter logic        SYNC_POL   = 1'b0,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    output logic        pix_req,
    output logic        pix_sof,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic [7:0]  enc_r,
    output logic [7:0]  enc_g,
    output logic [7:0]  enc_b,
    output logic        enc_de,
    output logic        enc_hsync,
    output logic        enc_vsync,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        running
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;

    // Stage 1: decoded timing for the pixel whose data arrives this cycle.
    logic            de_s1_q, hs_s1_q, vs_s1_q;
    logic            hs_raw, vs_raw;
    // Stage 2: encoder-facing registers.
    logic            enc_de_q, enc_hs_q, enc_vs_q;
    logic [23:0]     enc_rgb_q, enc_rgb_d;
    logic            underflow_q, underflow_d;

    logic            active_st, h_last, frame_end, h_act, v_act;

    // Raster decode from the registered counters.
    always_comb begin
        active_st = (state_q != StIdle);
        h_last    = (h_cnt_q == H_LAST);
        frame_end = h_last && (v_cnt_q == V_LAST);
        h_act     = (h_cnt_q >= H_ACT_FIRST) && (h_cnt_q <= H_ACT_LAST);
        v_act     = (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST);
        pix_req   = active_st && h_act && v_act;
        pix_sof   = pix_req && (h_cnt_q == H_ACT_FIRST) && (v_cnt_q == V_ACT_FIRST);
        hs_raw    = (active_st && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw    = (active_st && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Next-state and counter advance.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            // Dropping en exactly on the last pixel has nothing left to drain.
            StRun:   if (!en) state_d = frame_end ? StIdle : StDrain;
            // en is only looked at again once the frame has finished.
            StDrain: if (frame_end) state_d = en ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        // IDLE holds (0,0); leaving a frame always wraps back to (0,0).
        if (active_st) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
            if (h_last) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end
        end
    end

    // Data capture: source data is valid while the stage-1 de is high.
    always_comb begin
        enc_rgb_d = '0;
        if (de_s1_q) begin
            enc_rgb_d = pix_valid ? pix_data : FILL_COLOR;
        end
        // A fresh underflow beats a simultaneous clear.
        underflow_d = (de_s1_q && !pix_valid) || (underflow_q && !underflow_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            de_s1_q     <= 1'b0;
            hs_s1_q     <= ~SYNC_POL;
            vs_s1_q     <= ~SYNC_POL;
            enc_de_q    <= 1'b0;
            enc_hs_q    <= ~SYNC_POL;
            enc_vs_q    <= ~SYNC_POL;
            enc_rgb_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            de_s1_q     <= pix_req;
            hs_s1_q     <= hs_raw;
            vs_s1_q     <= vs_raw;
            enc_de_q    <= de_s1_q;
            enc_hs_q    <= hs_s1_q;
            enc_vs_q    <= vs_s1_q;
            enc_rgb_q   <= enc_rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign enc_r     = enc_rgb_q[23:16];
    assign enc_g     = enc_rgb_q[15:8];
    assign enc_b     = enc_rgb_q[7:0];
    assign enc_de    = enc_de_q;
    assign enc_hsync = enc_hs_q;
    assign enc_vsync = enc_vs_q;
    assign underflow = underflow_q;
    assign running   = (state_q != StIdle);

endmodule
